param_square_root_unit: RTL
===========================

PARAM_SQUARE_ROOT_UNIT -- requirements
Module: param_square_root_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, radicand width in bits; legal values are even and in the range 4..32.
REQ-002 SHALL have port Clock, input, 1 bit: single clock; all state is updated on the rising edge.
REQ-003 SHALL have port ResetN, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port St, input, 1 bit: start request, level-sensitive.
REQ-005 SHALL have port Rnd, input, 1 bit: mode select; 0 = floor result, 1 = round-to-nearest result.
REQ-006 SHALL have port N, input, WIDTH bits: unsigned radicand.
REQ-007 SHALL have port Busy, output, 1 bit: high while iterating.
REQ-008 SHALL have port Done, output, 1 bit: result valid.
REQ-009 SHALL have port Sqrt, output, WIDTH/2 bits: root result.
REQ-010 SHALL have port Rem, output, WIDTH/2+1 bits: remainder, N - floor(sqrt(N))^2.

Function
REQ-011 SHALL implement a three-state FSM with states IDLE, CALC and DONE; Busy = (state==CALC) and Done = (state==DONE), both decoded from registered state.
REQ-012 In IDLE, when St is sampled 1, the block SHALL capture N and Rnd into internal registers, clear the working root and remainder, and go to CALC.
REQ-013 CALC SHALL use digit-by-digit (restoring) integer square root: one root bit per cycle, MSB first, for exactly WIDTH/2 cycles, tracked by an iteration counter.
REQ-014 Latency: if St is first sampled high in IDLE at edge k, Done SHALL be 1 immediately after edge k+WIDTH/2.
REQ-015 Changes on N, Rnd or St during CALC SHALL be ignored; the captured operands are used.
REQ-016 Sqrt and Rem SHALL be registered and stable for the entire time Done=1.
REQ-017 With Rnd=0, Sqrt SHALL equal floor(sqrt(N)).
REQ-018 With Rnd=1, Sqrt SHALL equal floor(sqrt(N))+1 when Rem > floor(sqrt(N)), and floor(sqrt(N)) otherwise.
REQ-019 Rounding overflow: if the rounded value would equal 2^(WIDTH/2), Sqrt SHALL saturate to all ones.
REQ-020 Rem SHALL always report the floor remainder, regardless of Rnd.
REQ-021 Rem SHALL never exceed 2*floor(sqrt(N)); this is why Rem is WIDTH/2+1 bits wide.
REQ-022 In DONE, the FSM SHALL remain while St=1 and go to IDLE on the first edge at which St is sampled 0, giving a full four-phase St/Done handshake.
REQ-023 If St is already 0 on entry to DONE, Done SHALL be high for exactly one cycle.
REQ-024 A new St is only accepted from IDLE, so back-to-back operations require St to fall and rise again; the minimum gap between start edges is WIDTH/2+2 cycles.
REQ-025 N=0 SHALL yield Sqrt=0 and Rem=0 with the normal latency, with no special-case shortening.
REQ-026 In IDLE, Sqrt and Rem SHALL hold the last result.

Reset
REQ-027 ResetN=0 SHALL immediately force state to IDLE, drive Busy=0, Done=0, Sqrt=0 and Rem=0, and clear the iteration counter and captured operands, independent of Clock.
REQ-028 Reset asserted during CALC or DONE SHALL abort the operation with no partial result visible; after release, the first start behaves as from power-up.
REQ-029 The first edge after ResetN deasserts SHALL be able to sample St, so no wait cycles are needed after reset.

Verification
REQ-030 Bench SHALL check, at WIDTH=8, Rnd=0: N=0x51 -> Sqrt=0x9, Rem=0x00; N=0xFF -> Sqrt=0xF, Rem=0x1E; N=0x00 -> Sqrt=0x0, Rem=0x00.
REQ-031 Bench SHALL check, at WIDTH=8, Rnd=1: N=0x5A -> Sqrt=0x9, Rem=0x09; N=0x5B -> Sqrt=0xA, Rem=0x0A; N=0xFF -> Sqrt=0xF (saturated), Rem=0x1E.
REQ-032 Bench SHALL check latency at WIDTH=16: St rises and is sampled at edge k -> Busy high from k through k+7, Done high after edge k+8; N=0xFFFF -> Sqrt=0xFF, Rem=0x1FE.
REQ-033 Bench SHALL check the handshake: hold St high 5 cycles after Done -> Done stays high and Sqrt is stable; drop St -> Done low after the next edge; St pulsed for 1 cycle only -> Done high for exactly 1 cycle.
REQ-034 Bench SHALL check operand isolation: change N from 0x51 to 0xC4 mid-CALC -> result Sqrt=0x9 (WIDTH=8).
REQ-035 Bench SHALL check reset: assert ResetN=0 mid-CALC between clock edges -> Busy, Done, Sqrt and Rem are 0 without waiting for an edge; then start with N=0x90 -> Sqrt=0xC, Rem=0x00.
REQ-036 Bench SHALL check all 256 inputs at WIDTH=8 against a reference model in both Rnd modes.

Source files
------------

// File: rtl/param_square_root_unit.sv
// Sequential restoring integer square root: one root bit per cycle, MSB first,
// with optional round-to-nearest on the final root and a St/Done four-phase handshake.
module param_square_root_unit #(
    parameter int WIDTH = 16
) (
    input  logic               Clock,
    input  logic               ResetN,
    input  logic               St,
    input  logic               Rnd,
    input  logic [WIDTH-1:0]   N,
    output logic               Busy,
    output logic               Done,
    output logic [WIDTH/2-1:0] Sqrt,
    output logic [WIDTH/2:0]   Rem
);

    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(HALF + 1);
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] rad_q, rad_d;
    logic            rnd_q, rnd_d;
    logic [HALF-1:0] root_q, root_d;
    logic [HALF:0]   rem_q, rem_d;
    logic [HALF-1:0] sqrt_q, sqrt_d;
    logic [HALF:0]   remOut_q, remOut_d;

    logic [HALF+2:0] remShift;
    logic [HALF+2:0] trial;
    logic            ge;
    logic [HALF:0]   stepRem;
    logic [HALF-1:0] stepRoot;
    logic            roundUp;
    logic [HALF-1:0] rounded;

    // One restoring step: bring down the next two radicand bits and try 4*root+1.
    assign remShift = {rem_q, rad_q[WIDTH-1 -: 2]};
    assign trial    = {1'b0, root_q, 2'b01};
    assign ge       = (remShift >= trial);
    // A successful subtraction always leaves a value that fits HALF+1 bits,
    // so only the low bits take part in it.
    assign stepRem  = ge ? (remShift[HALF:0] - trial[HALF:0]) : remShift[HALF:0];
    assign stepRoot = {root_q[HALF-2:0], ge};

    // Round up when Rem > floor; an all-ones floor stays put (saturation).
    assign roundUp  = rnd_q && (stepRem > {1'b0, stepRoot});
    assign rounded  = (roundUp && !(&stepRoot)) ? (stepRoot + HALF'(1)) : stepRoot;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rad_q    <= '0;
            rnd_q    <= 1'b0;
            root_q   <= '0;
            rem_q    <= '0;
            sqrt_q   <= '0;
            remOut_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rad_q    <= rad_d;
            rnd_q    <= rnd_d;
            root_q   <= root_d;
            rem_q    <= rem_d;
            sqrt_q   <= sqrt_d;
            remOut_q <= remOut_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rad_d    = rad_q;
        rnd_d    = rnd_q;
        root_d   = root_q;
        rem_d    = rem_q;
        sqrt_d   = sqrt_q;
        remOut_d = remOut_q;

        unique case (state_q)
            IDLE: begin
                if (St) begin
                    rad_d   = N;
                    rnd_d   = Rnd;
                    root_d  = '0;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                rad_d  = rad_q << 2;
                root_d = stepRoot;
                rem_d  = stepRem;
                cnt_d  = cnt_q + CW'(1);
                // The last step writes the visible result on the same edge DONE is entered.
                if (cnt_q == LAST) begin
                    sqrt_d   = rounded;
                    remOut_d = stepRem;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (!St) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Busy = (state_q == CALC);
    assign Done = (state_q == DONE);
    assign Sqrt = sqrt_q;
    assign Rem  = remOut_q;

endmodule
